mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_wait_counter.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 154 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the data-memory access controller:
//   - state_t           : controller FSM states (IDLE, BUSY, DONE)
//   - BASE_ADDR_DEFAULT : default first byte address of data memory
//   - WORD_SHIFT        : byte-to-word shift (32-bit words)
//   - CNT_W             : wait counter width (covers latencies up to 15)
//   - word_index()      : byte address -> word index relative to a base
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
   localparam int          WORD_SHIFT        = 2;
   localparam int          CNT_W             = 4;

   // The two byte-offset bits are cleared before subtracting, so an
   // unaligned address always resolves to its containing word. The
   // subtraction wraps modulo 2^32.
   function automatic logic [31:0] word_index(input logic [31:0] addr,
                                              input logic [31:0] base);
      return ({addr[31:2], 2'b00} - base) >> WORD_SHIFT;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
// Down-counter that times a memory access.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value loaded when load is high
//   dec        : decrement by one; holds at zero
//   zero       : high while the count is zero
module mem_wait_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] count_q;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Bridges pipeline load/store requests to a fixed-latency data memory.
// A request seen in IDLE freezes the pipeline, the access runs for
// WAIT_CYCLES cycles in BUSY, and DONE releases the pipeline for one cycle
// while the same instruction is still presented.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   MEMread, MEMwrite   : load / store request (both high = store)
//   address, data       : byte address and store data from the pipeline
//   freeze              : pipeline stall while an access is in flight
//   MEM_result          : registered load data, held until the next load
//   mem_rd_en           : memory read enable (whole BUSY phase of a load)
//   mem_wr_en           : single-cycle write strobe (last BUSY cycle)
//   mem_addr, mem_wdata : latched word index and store data
//   mem_rdata           : memory read data
// Configuration macro: MEM_BOUNDS_CHECK_EN -- when defined, accesses below
// BASE_ADDR or at word index >= DEPTH suppress the memory enables and loads
// return zero; timing is unaffected.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          DEPTH       = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MEMread,
   input  logic        MEMwrite,
   input  logic [31:0] address,
   input  logic [31:0] data,
   output logic        freeze,
   output logic [31:0] MEM_result,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   state_t      state_d, state_q;
   logic [31:0] addr_idx_d, addr_idx_q;
   logic [31:0] wdata_d, wdata_q;
   logic        is_write_d, is_write_q;
   logic [31:0] mem_result_d, mem_result_q;
   logic        accept;
   logic        cnt_dec;
   logic        cnt_zero;
   logic        in_range;

   assign accept  = (state_q == IDLE) && (MEMread || MEMwrite);
   assign cnt_dec = (state_q == BUSY) && !cnt_zero;

   mem_wait_counter #(
      .WIDTH(CNT_W)
   ) u_wait_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .load_val(LOAD_VAL),
      .dec     (cnt_dec),
      .zero    (cnt_zero)
   );

`ifdef MEM_BOUNDS_CHECK_EN
   // The range verdict is taken once at acceptance and held with the
   // latched request so it cannot change mid-access.
   logic in_range_d, in_range_q;

   always_comb begin
      in_range_d = in_range_q;
      if (accept) begin
         in_range_d = (address >= BASE_ADDR) &&
                      (word_index(address, BASE_ADDR) < 32'(DEPTH));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_range_q <= 1'b0;
      end else begin
         in_range_q <= in_range_d;
      end
   end

   assign in_range = in_range_q;
`else
   assign in_range = 1'b1;
`endif

   // Next-state and output logic. freeze rises combinationally in the
   // accepting IDLE cycle so the pipeline stalls without a bubble.
   always_comb begin
      state_d      = state_q;
      addr_idx_d   = addr_idx_q;
      wdata_d      = wdata_q;
      is_write_d   = is_write_q;
      mem_result_d = mem_result_q;
      freeze       = 1'b0;
      mem_rd_en    = 1'b0;
      mem_wr_en    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               freeze     = 1'b1;
               addr_idx_d = word_index(address, BASE_ADDR);
               wdata_d    = data;
               is_write_d = MEMwrite;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            freeze    = 1'b1;
            mem_rd_en = !is_write_q && in_range;
            if (cnt_zero) begin
               mem_wr_en = is_write_q && in_range;
               if (!is_write_q) begin
                  mem_result_d = in_range ? mem_rdata : 32'h0;
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_idx_q   <= '0;
         wdata_q      <= '0;
         is_write_q   <= 1'b0;
         mem_result_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_idx_q   <= addr_idx_d;
         wdata_q      <= wdata_d;
         is_write_q   <= is_write_d;
         mem_result_q <= mem_result_d;
      end
   end

   assign MEM_result = mem_result_q;
   assign mem_addr   = addr_idx_q;
   assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Self-checking bench for mem_access_ctrl. A transaction-level reference
// model tracks each accepted request by its acceptance cycle and predicts
// every output from the cycle offset since acceptance. A small memory
// image answers reads. Directed cases cover the documented scenarios,
// followed by randomized traffic.
module tb_mem_access_ctrl;

   localparam int          WAIT  = 2;
   localparam logic [31:0] BASE  = 32'd1024;
   localparam int          DEPTH = 64;

   logic        clk;
   logic        rst_n;
   logic        MEMread;
   logic        MEMwrite;
   logic [31:0] address;
   logic [31:0] data;
   logic        freeze;
   logic [31:0] MEM_result;
   logic        mem_rd_en;
   logic        mem_wr_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] memImage [64];

   int checkCount = 0;
   int passCount  = 0;

   // Reference model state
   int          cycle      = 0;
   int          startCycle = 0;
   logic        active     = 1'b0;
   logic        mWrite     = 1'b0;
   logic        mInRange   = 1'b1;
   logic [31:0] mIdx       = '0;
   logic [31:0] mWdata     = '0;
   logic [31:0] expResult  = '0;

   // Observation counters for directed cases
   int freezeHigh = 0;
   int freezeLow  = 0;
   int wrPulses   = 0;
   int rdPulses   = 0;

   mem_access_ctrl #(
      .WAIT_CYCLES(WAIT),
      .BASE_ADDR  (BASE),
      .DEPTH      (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .MEMread   (MEMread),
      .MEMwrite  (MEMwrite),
      .address   (address),
      .data      (data),
      .freeze    (freeze),
      .MEM_result(MEM_result),
      .mem_rd_en (mem_rd_en),
      .mem_wr_en (mem_wr_en),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   assign mem_rdata = memImage[mem_addr[5:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   function automatic void clearCounters();
      freezeHigh = 0;
      freezeLow  = 0;
      wrPulses   = 0;
      rdPulses   = 0;
   endfunction

   // Drive one cycle of pipeline inputs, then predict and check outputs.
   task automatic applyStimulus(input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] dat);
      int   phase;
      logic expFreeze, expRd, expWr, inBusy;
      @(posedge clk);
      #1;
      MEMread  = rd;
      MEMwrite = wr;
      address  = addr;
      data     = dat;
      @(negedge clk);
      cycle++;
      // An access occupies its acceptance cycle, WAIT busy cycles and one
      // release cycle; only after that can another request be taken.
      if (active && ((cycle - startCycle) > WAIT + 1)) active = 1'b0;
      if (!active && (rd || wr)) begin
         active     = 1'b1;
         startCycle = cycle;
         mWrite     = wr;
         mIdx       = ({addr[31:2], 2'b00} - BASE) / 32'd4;
         mWdata     = dat;
         mInRange   = 1'b1;
`ifdef MEM_BOUNDS_CHECK_EN
         mInRange   = (addr >= BASE) && (mIdx < 32'(DEPTH));
`endif
      end
      phase     = cycle - startCycle;
      inBusy    = active && (phase >= 1) && (phase <= WAIT);
      expFreeze = active && (phase <= WAIT);
      expRd     = inBusy && !mWrite && mInRange;
      expWr     = inBusy && (phase == WAIT) && mWrite && mInRange;
      checkOutput("freeze", 32'(freeze), 32'(expFreeze));
      checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(expRd));
      checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(expWr));
      checkOutput("MEM_result", MEM_result, expResult);
      if (inBusy) begin
         checkOutput("mem_addr", mem_addr, mIdx);
         if (mWrite) checkOutput("mem_wdata", mem_wdata, mWdata);
      end
      if (inBusy && (phase == WAIT) && !mWrite) begin
         expResult = mInRange ? memImage[mIdx % 64] : 32'h0;
      end
      if (freeze) freezeHigh++; else freezeLow++;
      if (mem_wr_en) wrPulses++;
      if (mem_rd_en) rdPulses++;
   endtask

   // Present one instruction for as long as the pipeline would hold it
   // (frozen cycles plus the release cycle), then one idle cycle.
   task automatic doRequest(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] dat);
      for (int i = 0; i < WAIT + 2; i++) applyStimulus(rd, wr, addr, dat);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_freeze"}, 32'(freeze), 32'h0);
      checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 32'h0);
      checkOutput({tag, "_wr_en"}, 32'(mem_wr_en), 32'h0);
      checkOutput({tag, "_result"}, MEM_result, 32'h0);
      checkOutput({tag, "_addr"}, mem_addr, 32'h0);
      checkOutput({tag, "_wdata"}, mem_wdata, 32'h0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) memImage[i] = $urandom;
      memImage[2] = 32'hDEADBEEF;

      rst_n    = 1'b0;
      MEMread  = 1'b0;
      MEMwrite = 1'b0;
      address  = '0;
      data     = '0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Read 0x408: word 2, three frozen cycles, data visible afterwards
      clearCounters();
      doRequest(1'b1, 1'b0, 32'h0000_0408, 32'h0);
      checkOutput("read_freeze_cycles", 32'(freezeHigh), 32'd3);
      checkOutput("read_rd_cycles", 32'(rdPulses), 32'd2);
      checkOutput("read_result", MEM_result, 32'hDEADBEEF);

      // Write 0x400: one strobe, load result untouched
      clearCounters();
      doRequest(1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678);
      checkOutput("write_pulses", 32'(wrPulses), 32'd1);
      checkOutput("write_keeps_result", MEM_result, 32'hDEADBEEF);

      // Both strobes at 0x404 behave as a write to word 1
      clearCounters();
      doRequest(1'b1, 1'b1, 32'h0000_0406, 32'hA5A5_0001);
      checkOutput("both_pulses", 32'(wrPulses), 32'd1);
      checkOutput("both_no_read", 32'(rdPulses), 32'd0);

      // Reset one cycle into a write: no strobe, everything cleared
      clearCounters();
      applyStimulus(1'b0, 1'b1, 32'h0000_0410, 32'hCAFE_F00D);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      MEMread  = 1'b0;
      MEMwrite = 1'b0;
      @(negedge clk);
      checkAllZero("midreset");
      @(negedge clk);
      checkOutput("midreset_no_strobe", 32'(mem_wr_en), 32'h0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      active    = 1'b0;
      expResult = 32'h0;
      checkOutput("midreset_wr_total", 32'(wrPulses), 32'd0);
      doRequest(1'b1, 1'b0, 32'h0000_040C, 32'h0);

      // Two reads held back to back: one release cycle between them
      clearCounters();
      for (int i = 0; i < 2 * (WAIT + 2) - 1; i++)
         applyStimulus(1'b1, 1'b0, 32'h0000_0420, 32'h0);
      checkOutput("b2b_freeze_gap", 32'(freezeLow), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

`ifdef MEM_BOUNDS_CHECK_EN
      clearCounters();
      doRequest(1'b1, 1'b0, 32'h0000_0500, 32'h0);
      checkOutput("oob_no_read", 32'(rdPulses), 32'd0);
      checkOutput("oob_result", MEM_result, 32'h0);
`endif

      // Randomized traffic, including wrapping addresses
      for (int i = 0; i < 400; i++) begin
         logic        rd, wr;
         logic [31:0] addr;
         rd = ($urandom_range(0, 2) == 0);
         wr = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         else addr = BASE + 32'($urandom_range(0, 255));
         applyStimulus(rd, wr, addr, $urandom);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
